// File: rtl/run_monitor_pkg.sv
// Shared types and default parameters for the run monitor.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_NUM_STOP     = 4;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_DRAIN_CYCLES = 2;
  localparam int DEF_TRACE_DEPTH  = 8;

endpackage

// File: rtl/run_monitor_trace.sv
// Circular PC trace buffer; read index 0 is the most recent entry.
// Only instantiated when RUN_MONITOR_TRACE_EN is defined.
module run_monitor_trace
  import run_monitor_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_TRACE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [IDX_W-1:0]  rd_slot;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (clr) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (wr_en) begin
      ptr_d = ptr_q + IDX_W'(1);
      if (count_q != FULL) count_d = count_q + (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries beyond count are never returned.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[ptr_q] <= wr_data;
  end

  // Pointer arithmetic wraps modulo DEPTH because DEPTH is a power of two.
  assign rd_slot = ptr_q - IDX_W'(1) - rd_idx;
  assign rd_data = ({1'b0, rd_idx} < count_q) ? mem_q[rd_slot] : '0;
  assign count   = count_q;

endmodule

// File: rtl/run_monitor.sv
// Run monitor: gates the CPU clock enable until a stop address hits or a timeout expires.
// Optional PC trace buffer built when RUN_MONITOR_TRACE_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for start, CPU stopped
// ST_RUN   | CPU running, watching stop addresses and timeout
// ST_DRAIN | stop hit, CPU runs DRAIN_CYCLES more cycles
// ST_DONE  | run finished, results held until next start
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int NUM_STOP     = DEF_NUM_STOP,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int TRACE_DEPTH  = DEF_TRACE_DEPTH
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic [ADDR_W-1:0]                              pc,
  input  logic [NUM_STOP*ADDR_W-1:0]                     stop_addr,
  input  logic [NUM_STOP-1:0]                            stop_en,
  input  logic [CNT_W-1:0]                               timeout_limit,
  output logic                                           cpu_en,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           timed_out,
  output logic [((NUM_STOP > 1) ? $clog2(NUM_STOP) : 1)-1:0] hit_idx,
  output logic [CNT_W-1:0]                               cycle_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0]                 trace_rd_idx,
  output logic [ADDR_W-1:0]                              trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]                   trace_count
);

  localparam int HIT_W = (NUM_STOP > 1) ? $clog2(NUM_STOP) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              timed_out_q, timed_out_d;
  logic [HIT_W-1:0]  hit_idx_q, hit_idx_d;
  logic              match_q, match_d;
  logic [HIT_W-1:0]  match_idx_q, match_idx_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              cmp_hit;
  logic [HIT_W-1:0]  cmp_idx;
  logic              run_start;
  logic              timeout_hit;

  // Descending scan so the lowest matching channel is the one left standing.
  always_comb begin
    cmp_hit = 1'b0;
    cmp_idx = '0;
    for (int k = NUM_STOP - 1; k >= 0; k--) begin
      if (stop_en[k] && (pc == stop_addr[k*ADDR_W +: ADDR_W])) begin
        cmp_hit = 1'b1;
        cmp_idx = HIT_W'(k);
      end
    end
  end

  assign run_start   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (timeout_limit != '0) && (cnt_inc >= timeout_limit);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    hit_idx_d   = hit_idx_q;
    drain_d     = drain_q;
    // Compare result is only meaningful for pc values seen while running.
    match_d     = cmp_hit && (state_q == ST_RUN);
    match_idx_d = cmp_idx;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_start) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          timed_out_d = 1'b0;
          hit_idx_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (match_q) begin
          hit_idx_d = match_idx_q;
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRN_LOAD;
          end
        end else if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_inc;
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - DRN_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      hit_idx_q   <= '0;
      drain_q     <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      hit_idx_q   <= hit_idx_d;
      drain_q     <= drain_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
    end
  end

  assign cpu_en      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign busy        = cpu_en;
  assign done        = (state_q == ST_DONE);
  assign timed_out   = timed_out_q;
  assign hit_idx     = hit_idx_q;
  assign cycle_count = cnt_q;

`ifdef RUN_MONITOR_TRACE_EN
  run_monitor_trace #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (run_start),
    .wr_en   (cpu_en),
    .wr_data (pc),
    .rd_idx  (trace_rd_idx),
    .rd_data (trace_rd_data),
    .count   (trace_count)
  );
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_rd_idx;
  assign trace_rd_data    = '0;
  assign trace_count      = '0;
`endif

endmodule
